// File: rtl/i2c_regmap_pkg.sv
// Shared types and constants for the I2C register-map controller.
package i2c_regmap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PTR  = 2'd1,
        ST_WR   = 2'd2,
        ST_RD   = 2'd3
    } state_t;

    localparam logic [7:0] TX_IDLE_BYTE = 8'hFF;
    localparam logic [7:0] REG_RESET    = 8'h00;

endpackage

// File: rtl/i2c_regmap_ctrl_if.sv
// Bundle of peripheral byte events, fabric register port and write-event outputs.
interface i2c_regmap_ctrl_if #(
    parameter int unsigned NUM_REGS = 16
);
    localparam int unsigned PTR_W = $clog2(NUM_REGS);

    logic             i2c_start;
    logic             i2c_rw;
    logic             i2c_stop;
    logic             i2c_rx_valid;
    logic [7:0]       i2c_rx_data;
    logic             i2c_tx_req;
    logic [7:0]       i2c_tx_data;
    logic             i2c_tx_valid;
    logic [PTR_W-1:0] reg_addr;
    logic             reg_we;
    logic [7:0]       reg_wdata;
    logic             reg_ready;
    logic [7:0]       reg_rdata;
    logic             wr_event;
    logic [PTR_W-1:0] wr_event_addr;

    modport slave (
        input  i2c_start, i2c_rw, i2c_stop, i2c_rx_valid, i2c_rx_data, i2c_tx_req,
        input  reg_addr, reg_we, reg_wdata,
        output i2c_tx_data, i2c_tx_valid, reg_ready, reg_rdata, wr_event, wr_event_addr
    );

    modport master (
        output i2c_start, i2c_rw, i2c_stop, i2c_rx_valid, i2c_rx_data, i2c_tx_req,
        output reg_addr, reg_we, reg_wdata,
        input  i2c_tx_data, i2c_tx_valid, reg_ready, reg_rdata, wr_event, wr_event_addr
    );

endinterface

// File: rtl/i2c_regmap_ram.sv
// NUM_REGS x 8 register file: one prioritised write port (I2C over fabric) and two
// registered read ports. Reads return the pre-write value on a same-cycle collision.
module i2c_regmap_ram
    import i2c_regmap_pkg::*;
#(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned PTR_W    = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_i2c_we,
    input  logic [PTR_W-1:0] i_i2c_waddr,
    input  logic [7:0]       i_i2c_wdata,
    input  logic             i_fab_we,
    input  logic [PTR_W-1:0] i_fab_waddr,
    input  logic [7:0]       i_fab_wdata,
    input  logic             i_i2c_re,
    input  logic             i_i2c_idle,
    input  logic [PTR_W-1:0] i_i2c_raddr,
    input  logic [PTR_W-1:0] i_fab_raddr,
    output logic [7:0]       o_i2c_rdata,
    output logic [7:0]       o_fab_rdata
);

    logic [7:0] r_mem [NUM_REGS];
    logic [7:0] r_i2c_rdata;
    logic [7:0] r_fab_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                r_mem[i] <= REG_RESET;
            end
            r_i2c_rdata <= TX_IDLE_BYTE;
            r_fab_rdata <= REG_RESET;
        end else begin
            if (i_i2c_we) begin
                r_mem[i_i2c_waddr] <= i_i2c_wdata;
            end else if (i_fab_we) begin
                r_mem[i_fab_waddr] <= i_fab_wdata;
            end

            // I2C read port holds its byte between requests; non-RD requests get the idle byte
            if (i_i2c_re) begin
                r_i2c_rdata <= r_mem[i_i2c_raddr];
            end else if (i_i2c_idle) begin
                r_i2c_rdata <= TX_IDLE_BYTE;
            end

            r_fab_rdata <= r_mem[i_fab_raddr];
        end
    end

    assign o_i2c_rdata = r_i2c_rdata;
    assign o_fab_rdata = r_fab_rdata;

endmodule

// File: rtl/i2c_regmap_ctrl.sv
// I2C transaction sequencer: pointer load, register write/read with optional auto-increment.
// Build option: define REGMAP_AUTOINC_EN to advance the pointer after each WR/RD byte.
module i2c_regmap_ctrl
    import i2c_regmap_pkg::*;
#(
    parameter int unsigned NUM_REGS = 16
) (
    input  logic            clk,
    input  logic            rst,
    i2c_regmap_ctrl_if.slave bus
);

    localparam int unsigned PTR_W = $clog2(NUM_REGS);

`ifdef REGMAP_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    state_t           r_state;
    logic [PTR_W-1:0] r_ptr;
    logic             r_wr_event;
    logic [PTR_W-1:0] r_wr_event_addr;
    logic             r_tx_valid;

    logic             w_in_rd;
    logic             w_tx_hit;
    logic             w_tx_idle;
    logic             w_i2c_we;
    logic             w_ptr_load;
    logic             w_reg_ready;
    logic             w_fab_we;
    logic [PTR_W-1:0] w_ptr_inc;
    logic [7:0]       w_i2c_rdata;
    logic [7:0]       w_fab_rdata;

    assign w_in_rd     = (r_state == ST_RD);
    assign w_tx_hit    = bus.i2c_tx_req & w_in_rd;
    assign w_tx_idle   = bus.i2c_tx_req & ~w_in_rd;
    // A START in the same cycle as a payload byte discards the byte
    assign w_i2c_we    = (r_state == ST_WR) & bus.i2c_rx_valid & ~bus.i2c_start;
    assign w_ptr_load  = (r_state == ST_PTR) & bus.i2c_rx_valid & ~bus.i2c_start;
    assign w_reg_ready = ~((r_state == ST_WR) & bus.i2c_rx_valid);
    assign w_fab_we    = bus.reg_we & w_reg_ready;
    assign w_ptr_inc   = AUTOINC ? (r_ptr + PTR_W'(1)) : r_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_ptr           <= '0;
            r_wr_event      <= 1'b0;
            r_wr_event_addr <= '0;
            r_tx_valid      <= 1'b0;
        end else begin
            r_wr_event <= w_i2c_we;
            r_tx_valid <= bus.i2c_tx_req;
            if (w_i2c_we) begin
                r_wr_event_addr <= r_ptr;
            end

            // START overrides everything; STOP is applied after the byte of the same cycle
            if (bus.i2c_start) begin
                r_state <= bus.i2c_rw ? ST_RD : ST_PTR;
            end else if (bus.i2c_stop) begin
                r_state <= ST_IDLE;
            end else if (w_ptr_load) begin
                r_state <= ST_WR;
            end

            if (w_ptr_load) begin
                r_ptr <= bus.i2c_rx_data[PTR_W-1:0];
            end else if (w_i2c_we || w_tx_hit) begin
                r_ptr <= w_ptr_inc;
            end
        end
    end

    i2c_regmap_ram #(
        .NUM_REGS (NUM_REGS),
        .PTR_W    (PTR_W)
    ) u_ram (
        .clk         (clk),
        .rst         (rst),
        .i_i2c_we    (w_i2c_we),
        .i_i2c_waddr (r_ptr),
        .i_i2c_wdata (bus.i2c_rx_data),
        .i_fab_we    (w_fab_we),
        .i_fab_waddr (bus.reg_addr),
        .i_fab_wdata (bus.reg_wdata),
        .i_i2c_re    (w_tx_hit),
        .i_i2c_idle  (w_tx_idle),
        .i_i2c_raddr (r_ptr),
        .i_fab_raddr (bus.reg_addr),
        .o_i2c_rdata (w_i2c_rdata),
        .o_fab_rdata (w_fab_rdata)
    );

    assign bus.i2c_tx_data   = w_i2c_rdata;
    assign bus.i2c_tx_valid  = r_tx_valid;
    assign bus.reg_ready     = w_reg_ready;
    assign bus.reg_rdata     = w_fab_rdata;
    assign bus.wr_event      = r_wr_event;
    assign bus.wr_event_addr = r_wr_event_addr;

endmodule

// File: tb/tb_i2c_regmap_ctrl.sv
// Self-checking bench for i2c_regmap_ctrl: directed scenarios then random traffic vs a reference model.
module tb_i2c_regmap_ctrl;

    localparam int unsigned NUM_REGS = 16;
    localparam int unsigned PTR_W    = 4;

`ifdef REGMAP_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    typedef struct {
        bit             rst;
        bit             start;
        bit             rw;
        bit             stop;
        bit             rx_valid;
        bit [7:0]       rx_data;
        bit             tx_req;
        bit [PTR_W-1:0] addr;
        bit             we;
        bit [7:0]       wdata;
    } stim_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    i2c_regmap_ctrl_if #(.NUM_REGS(NUM_REGS)) bus ();

    i2c_regmap_ctrl #(.NUM_REGS(NUM_REGS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: register contents, pointer and transaction phase
    localparam int M_IDLE = 0, M_PTR = 1, M_WR = 2, M_RD = 3;
    bit [7:0] m_regs [NUM_REGS];
    int       m_ptr;
    int       m_mode;
    bit [7:0] e_tx_data;
    bit       e_tx_valid;
    bit       e_wr_event;
    int       e_wr_addr;
    bit [7:0] e_rdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic stim_t nop();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    function automatic bit model_ready(input stim_t s);
        return !(m_mode == M_WR && s.rx_valid);
    endfunction

    task automatic model_step(input stim_t s);
        bit ready;
        if (s.rst) begin
            foreach (m_regs[i]) m_regs[i] = 8'h00;
            m_ptr = 0; m_mode = M_IDLE;
            e_tx_data = 8'hFF; e_tx_valid = 0; e_wr_event = 0; e_rdata = 8'h00;
            return;
        end
        ready      = model_ready(s);
        e_rdata    = m_regs[s.addr];
        e_tx_valid = s.tx_req;
        if (s.tx_req) begin
            if (m_mode == M_RD) begin
                e_tx_data = m_regs[m_ptr];
                if (AUTOINC) m_ptr = (m_ptr + 1) % NUM_REGS;
            end else begin
                e_tx_data = 8'hFF;
            end
        end
        e_wr_event = 0;
        if (s.start) begin
            m_mode = s.rw ? M_RD : M_PTR;
        end else begin
            if (s.rx_valid) begin
                if (m_mode == M_PTR) begin
                    m_ptr  = s.rx_data % NUM_REGS;
                    m_mode = M_WR;
                end else if (m_mode == M_WR) begin
                    m_regs[m_ptr] = s.rx_data;
                    e_wr_event    = 1;
                    e_wr_addr     = m_ptr;
                    if (AUTOINC) m_ptr = (m_ptr + 1) % NUM_REGS;
                end
            end
            if (s.stop) m_mode = M_IDLE;
        end
        if (s.we && ready) m_regs[s.addr] = s.wdata;
    endtask

    task automatic drive(input stim_t s);
        rst              = s.rst;
        bus.i2c_start    = s.start;
        bus.i2c_rw       = s.rw;
        bus.i2c_stop     = s.stop;
        bus.i2c_rx_valid = s.rx_valid;
        bus.i2c_rx_data  = s.rx_data;
        bus.i2c_tx_req   = s.tx_req;
        bus.reg_addr     = s.addr;
        bus.reg_we       = s.we;
        bus.reg_wdata    = s.wdata;
        #1;
        if (!s.rst) chk("reg_ready", 32'(bus.reg_ready), 32'(model_ready(s)));
        @(posedge clk);
        #1;
        model_step(s);
        chk("tx_valid", 32'(bus.i2c_tx_valid), 32'(e_tx_valid));
        chk("tx_data", 32'(bus.i2c_tx_data), 32'(e_tx_data));
        chk("wr_event", 32'(bus.wr_event), 32'(e_wr_event));
        if (e_wr_event) chk("wr_event_addr", 32'(bus.wr_event_addr), 32'(e_wr_addr));
        chk("reg_rdata", 32'(bus.reg_rdata), 32'(e_rdata));
    endtask

    task automatic do_start(input bit rw);
        stim_t s = nop(); s.start = 1; s.rw = rw; drive(s);
    endtask
    task automatic do_rx(input bit [7:0] d);
        stim_t s = nop(); s.rx_valid = 1; s.rx_data = d; drive(s);
    endtask
    task automatic do_tx();
        stim_t s = nop(); s.tx_req = 1; drive(s);
    endtask
    task automatic do_stop();
        stim_t s = nop(); s.stop = 1; drive(s);
    endtask
    task automatic fab_read(input int a);
        stim_t s = nop(); s.addr = PTR_W'(a); drive(s);
    endtask

    initial begin
        stim_t s;
        s = nop(); s.rst = 1;
        drive(s); drive(s);
        chk("rst_tx_data", 32'(bus.i2c_tx_data), 32'h FF);
        chk("rst_rdata", 32'(bus.reg_rdata), 32'h0);
        s = nop(); drive(s);

        // 1: pointer then two data bytes
        do_start(0); do_rx(8'h03);
        do_rx(8'hA5);
        chk("t1_ev_addr3", 32'(bus.wr_event_addr), 32'd3);
        do_rx(8'h5A);
        chk("t1_ev_addr4", 32'(bus.wr_event_addr), AUTOINC ? 32'd4 : 32'd3);
        do_stop();
        fab_read(3); chk("t1_reg3", 32'(bus.reg_rdata), AUTOINC ? 32'hA5 : 32'h5A);
        fab_read(4); chk("t1_reg4", 32'(bus.reg_rdata), AUTOINC ? 32'h5A : 32'h00);

        // 2: pointer write then repeated-START read
        do_start(0); do_rx(8'h03); do_start(1);
        do_tx(); chk("t2_tx0", 32'(bus.i2c_tx_data), AUTOINC ? 32'hA5 : 32'h5A);
        do_tx(); chk("t2_tx1", 32'(bus.i2c_tx_data), 32'h5A);
        do_tx(); chk("t2_tx_ptr5", 32'(bus.i2c_tx_data), AUTOINC ? 32'h00 : 32'h5A);
        do_stop();

        // 3: pointer wrap and pointer truncation
        do_start(0); do_rx(8'h0F); do_rx(8'h11); do_rx(8'h22); do_stop();
        fab_read(15); chk("t3_reg15", 32'(bus.reg_rdata), AUTOINC ? 32'h11 : 32'h22);
        fab_read(0);  chk("t3_reg0", 32'(bus.reg_rdata), AUTOINC ? 32'h22 : 32'h00);
        do_start(0); do_rx(8'h1F); do_start(1); do_tx();
        chk("t3_ptr_trunc", 32'(bus.i2c_tx_data), AUTOINC ? 32'h11 : 32'h22);
        do_stop();

        // 4: I2C write beats fabric write; fabric retries
        do_start(0); do_rx(8'h07);
        s = nop(); s.rx_valid = 1; s.rx_data = 8'h44; s.we = 1; s.addr = 4'd7; s.wdata = 8'h33;
        drive(s);
        s = nop(); s.we = 1; s.addr = 4'd7; s.wdata = 8'h33;
        drive(s);
        do_stop();
        fab_read(7); chk("t4_reg7", 32'(bus.reg_rdata), 32'h33);

        // 5: idle tx request and START+byte collision
        do_tx(); chk("t5_idle_ff", 32'(bus.i2c_tx_data), 32'hFF);
        s = nop(); s.start = 1; s.rx_valid = 1; s.rx_data = 8'h09; drive(s);
        do_start(1); do_tx(); do_stop();

        // 6: reset mid-write, stray byte afterwards
        do_start(0); do_rx(8'h02); do_rx(8'h77);
        s = nop(); s.rst = 1; drive(s);
        do_rx(8'h88);
        for (int a = 0; a < int'(NUM_REGS); a++) begin
            fab_read(a);
            chk("t6_reg_clear", 32'(bus.reg_rdata), 32'h00);
        end

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            s = nop();
            s.rst      = ($urandom_range(0, 299) == 0);
            s.start    = ($urandom_range(0, 99) < 6);
            s.rw       = 1'($urandom);
            s.stop     = ($urandom_range(0, 99) < 5);
            s.rx_valid = ($urandom_range(0, 99) < 35);
            s.rx_data  = 8'($urandom);
            s.tx_req   = ($urandom_range(0, 99) < 25);
            s.addr     = PTR_W'($urandom);
            s.we       = ($urandom_range(0, 99) < 30);
            s.wdata    = 8'($urandom);
            drive(s);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
